pulse_seq_ctrl: RTL and testbench



---
 rtl/pulse_pkg.sv | 26 ++
 rtl/pulse_dcnt.sv | 28 ++
 rtl/pulse_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-state sequencer: FSM encoding, config
// register addresses and default widths.
package pulse_pkg;

    localparam int TW_DEF = 20;
    localparam int RW_DEF = 16;
    localparam int GW_DEF = 20;

    localparam logic [1:0] ADDR_PLUSE  = 2'd0;
    localparam logic [1:0] ADDR_DUMP   = 2'd1;
    localparam logic [1:0] ADDR_REPEAT = 2'd2;
    localparam logic [1:0] ADDR_GAP    = 2'd3;

    typedef enum logic [8:0] {
        S_IDLE    = 9'b000000001,
        S_LOAD_P  = 9'b000000010,
        S_LOAD_D  = 9'b000000100,
        S_RELEASE = 9'b000001000,
        S_SETTLE  = 9'b000010000,
        S_RUN     = 9'b000100000,
        S_STEP    = 9'b001000000,
        S_GAP     = 9'b010000000,
        S_FIN     = 9'b100000000
    } state_t;

endpackage

// File: rtl/pulse_dcnt.sv
// Loadable down-counter that never goes below 1; a load of 0 is taken as 1
// so a zero duration still produces a one-cycle interval.
module pulse_dcnt #(
    parameter int W = 20
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= W'(1);
        end else if (i_load) begin
            r_count <= (i_val == '0) ? W'(1) : i_val;
        end else if (i_dec && (r_count > W'(1))) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expire = (r_count == W'(1));

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Drives the PLUSE/DUMP pulse-state block through repeated scans: loads its
// time registers, releases its reset, steps it on timecount and gaps scans.
module pulse_seq_ctrl
    import pulse_pkg::*;
#(
    parameter int TW = TW_DEF,
    parameter int RW = RW_DEF,
    parameter int GW = GW_DEF
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [15:0]   cfg_data,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] timecount_in,
    input  logic          state_over_n_in,
    output logic          sm_rst_n,
    output logic          clken_p,
    output logic          load,
    output logic          loadchoice,
    output logic [15:0]   datain,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] scan_cnt
);

    state_t        r_state;
    state_t        w_state_next;
    logic [15:0]   r_pluse_time;
    logic [15:0]   r_dump_time;
    logic [RW-1:0] r_repeat;
    logic [GW-1:0] r_gap;
    logic [RW-1:0] r_scan_cnt;
    logic          w_tmr_expire;
    logic          w_gap_expire;
    logic          w_gap_entry;
    logic          w_run_start;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_pluse_time <= '0;
            r_dump_time  <= '0;
            r_repeat     <= '0;
            r_gap        <= '0;
        end else if (cfg_we && (r_state == S_IDLE)) begin
            case (cfg_addr)
                ADDR_PLUSE:  r_pluse_time <= cfg_data;
                ADDR_DUMP:   r_dump_time  <= cfg_data;
                ADDR_REPEAT: r_repeat     <= RW'(cfg_data);
                default:     r_gap        <= GW'(cfg_data);
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_state_next = (r_repeat != '0) ? S_LOAD_P : S_FIN;
                    end
                end
                S_LOAD_P:  w_state_next = S_LOAD_D;
                S_LOAD_D:  w_state_next = S_RELEASE;
                S_RELEASE: w_state_next = S_SETTLE;
                S_SETTLE:  w_state_next = S_RUN;
                S_RUN: begin
                    // STOP from the block wins over a coincident timer expiry
                    if (!state_over_n_in) begin
                        w_state_next = S_GAP;
                    end else if (w_tmr_expire) begin
                        w_state_next = S_STEP;
                    end
                end
                S_STEP: w_state_next = S_SETTLE;
                S_GAP: begin
                    if (w_gap_expire) begin
                        w_state_next = (r_scan_cnt == r_repeat) ? S_FIN : S_LOAD_P;
                    end
                end
                S_FIN:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_gap_entry = (r_state == S_RUN) && (w_state_next == S_GAP);
    assign w_run_start = (r_state == S_IDLE) && (w_state_next == S_LOAD_P);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
        end else if (w_run_start) begin
            r_scan_cnt <= '0;
        end else if (w_gap_entry && (r_scan_cnt != '1)) begin
            r_scan_cnt <= r_scan_cnt + RW'(1);
        end
    end

    pulse_dcnt #(.W(TW)) u_state_tmr (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .i_load   (r_state == S_SETTLE),
        .i_val    (timecount_in),
        .i_dec    (r_state == S_RUN),
        .o_expire (w_tmr_expire)
    );

    pulse_dcnt #(.W(GW)) u_gap_tmr (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .i_load   (w_gap_entry),
        .i_val    (r_gap),
        .i_dec    (r_state == S_GAP),
        .o_expire (w_gap_expire)
    );

    // All outputs decode the registered state, so an async reset clears them at once
    assign load       = (r_state == S_LOAD_P) || (r_state == S_LOAD_D);
    assign loadchoice = (r_state == S_LOAD_D);
    assign datain     = (r_state == S_LOAD_P) ? r_pluse_time :
                        (r_state == S_LOAD_D) ? r_dump_time  : 16'd0;
    assign sm_rst_n   = (r_state == S_RELEASE) || (r_state == S_SETTLE) ||
                        (r_state == S_RUN)     || (r_state == S_STEP);
    assign clken_p    = (r_state == S_STEP);
    assign done       = (r_state == S_FIN);
    assign busy       = (r_state != S_IDLE);
    assign scan_cnt   = r_scan_cnt;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: stimulus queues expected load/clken/done
// events, a negedge monitor pops and compares them; a small model plays the block.
module tb_pulse_seq_ctrl;

    localparam int TW = 20;
    localparam int RW = 16;
    localparam int K_LOAD = 0;
    localparam int K_CLK  = 1;
    localparam int K_DONE = 2;

    logic          clk_sys = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [15:0]   cfg_data;
    logic          start;
    logic          abort;
    logic [TW-1:0] timecount_in;
    logic          state_over_n_in;
    logic          sm_rst_n;
    logic          clken_p;
    logic          load;
    logic          loadchoice;
    logic [15:0]   datain;
    logic          busy;
    logic          done;
    logic [RW-1:0] scan_cnt;

    always #5 clk_sys = ~clk_sys;

    pulse_seq_ctrl dut (
        .clk_sys         (clk_sys),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .start           (start),
        .abort           (abort),
        .timecount_in    (timecount_in),
        .state_over_n_in (state_over_n_in),
        .sm_rst_n        (sm_rst_n),
        .clken_p         (clken_p),
        .load            (load),
        .loadchoice      (loadchoice),
        .datain          (datain),
        .busy            (busy),
        .done            (done),
        .scan_cnt        (scan_cnt)
    );

    typedef struct {
        int kind;
        int val;
        int dly;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   last_cyc   = 0;
    int   rises      = 0;
    logic prev_sm    = 1'b0;
    bit   mon_en     = 1'b0;
    int   k_model    = 1;
    int   pulses     = 0;

    // Pulse-state block stand-in: reports STOP after k_model steps in a scan
    initial begin
        int p;
        forever begin
            @(negedge clk_sys);
            p = sm_rst_n ? pulses + int'(clken_p) : 0;
            pulses = p;
            state_over_n_in = !(sm_rst_n && (p >= k_model));
        end
    end

    initial begin
        exp_t e;
        int   kind;
        int   val;
        int   dly;
        bit   multi;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (rst_n && sm_rst_n && !prev_sm) rises++;
            prev_sm = sm_rst_n;
            if (rst_n && mon_en && (load || clken_p || done)) begin
                kind  = load ? K_LOAD : (clken_p ? K_CLK : K_DONE);
                val   = load ? ((loadchoice ? 65536 : 0) + int'(datain)) :
                        (done ? int'(scan_cnt) : 0);
                dly   = cyc - last_cyc;
                last_cyc = cyc;
                multi = (int'(load) + int'(clken_p) + int'(done)) > 1;
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: got kind=%0d val=%0d dly=%0d, required none", kind, val, dly);
                end else begin
                    e = q.pop_front();
                    if (e.kind != kind || e.val != val || (e.dly != 0 && e.dly != dly) || multi) begin
                        mismatched++;
                        $display("FAIL event: got kind=%0d val=%0d dly=%0d multi=%0d, required kind=%0d val=%0d dly=%0d",
                                 kind, val, dly, multi, e.kind, e.val, e.dly);
                    end else begin
                        $display("event ok kind=%0d val=%0d dly=%0d", kind, val, dly);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end else begin
            $display("check ok %s = %0d", name, act);
        end
    endtask

    task automatic push(input int kind, input int val, input int dly);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.dly  = dly;
        q.push_back(e);
    endtask

    task automatic cfg(input logic [1:0] a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d[15:0];
        @(posedge clk_sys); #1;
        cfg_we   = 1'b0;
    endtask

    // Expected events for 'scans' complete scans; done only if the run finishes
    task automatic push_run(input int rep, input int gap, input int pt, input int dt,
                            input int t, input int k, input int scans);
        int tp;
        int gp;
        tp = (t == 0) ? 1 : t;
        gp = (gap == 0) ? 1 : gap;
        for (int s = 0; s < scans; s++) begin
            push(K_LOAD, pt, (s == 0) ? 0 : gp + 3);
            push(K_LOAD, 65536 + dt, 1);
            push(K_CLK, 0, tp + 3);
            for (int j = 1; j < k; j++) push(K_CLK, 0, tp + 2);
        end
        if (scans == rep) push(K_DONE, rep, gp + 3);
    endtask

    task automatic start_pulse();
        rises = 0;
        start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles, required busy=0", name, budget);
        end
    endtask

    task automatic end_check(input string name, input int exp_rises);
        repeat (3) begin
            @(posedge clk_sys); #1;
        end
        chk({name, "_pending_events"}, q.size(), 0);
        chk({name, "_sm_rst_n_rises"}, rises, exp_rises);
        q.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_sm_rst_n"},   int'(sm_rst_n),   0);
        chk({name, "_clken_p"},    int'(clken_p),    0);
        chk({name, "_load"},       int'(load),       0);
        chk({name, "_loadchoice"}, int'(loadchoice), 0);
        chk({name, "_datain"},     int'(datain),     0);
        chk({name, "_busy"},       int'(busy),       0);
        chk({name, "_done"},       int'(done),       0);
        chk({name, "_scan_cnt"},   int'(scan_cnt),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 16'd0;
        start = 1'b0;
        abort = 1'b0;
        timecount_in = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk_sys); #1;
        mon_en = 1'b1;

        // Single scan, two steps of 12 cycles, gap 10
        cfg(2'd0, 50); cfg(2'd1, 200); cfg(2'd2, 1); cfg(2'd3, 10);
        timecount_in = TW'(12); k_model = 2;
        push_run(1, 10, 50, 200, 12, 2, 1);
        start_pulse();
        wait_idle("t1", 300);
        chk("t1_scan_cnt", int'(scan_cnt), 1);
        end_check("t1", 1);

        // Three scans, zero gap; a PLUSETIME write while busy must be ignored
        cfg(2'd2, 3); cfg(2'd3, 0);
        timecount_in = TW'(4); k_model = 2;
        push_run(3, 0, 50, 200, 4, 2, 3);
        start_pulse();
        repeat (3) begin
            @(posedge clk_sys); #1;
        end
        cfg(2'd0, 99);
        wait_idle("t2", 300);
        chk("t2_scan_cnt", int'(scan_cnt), 3);
        end_check("t2", 3);

        // Zero timecount: steps three cycles apart, old PLUSETIME still loaded
        cfg(2'd2, 1); cfg(2'd3, 1);
        timecount_in = TW'(0); k_model = 3;
        push_run(1, 1, 50, 200, 0, 3, 1);
        start_pulse();
        wait_idle("t3", 300);
        chk("t3_scan_cnt", int'(scan_cnt), 1);
        end_check("t3", 1);

        // Abort during RUN of the second of four scans
        cfg(2'd2, 4); cfg(2'd3, 2);
        timecount_in = TW'(5); k_model = 3;
        push_run(4, 2, 50, 200, 5, 3, 1);
        push(K_LOAD, 50, 5);
        push(K_LOAD, 65536 + 200, 1);
        start_pulse();
        n = 0;
        while (!(scan_cnt == 1 && sm_rst_n) && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("t4_reached_scan2", int'(scan_cnt == 1 && sm_rst_n), 1);
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        abort = 1'b1;
        @(posedge clk_sys); #1;
        abort = 1'b0;
        chk("t4_busy",     int'(busy),     0);
        chk("t4_sm_rst_n", int'(sm_rst_n), 0);
        chk("t4_load",     int'(load),     0);
        chk("t4_clken_p",  int'(clken_p),  0);
        chk("t4_scan_cnt", int'(scan_cnt), 1);
        repeat (10) begin
            @(posedge clk_sys); #1;
        end
        chk("t4_scan_cnt_held", int'(scan_cnt), 1);
        end_check("t4", 2);

        // Config writes accepted again after the abort
        cfg(2'd0, 77); cfg(2'd2, 1); cfg(2'd3, 0);
        timecount_in = TW'(2); k_model = 1;
        push_run(1, 0, 77, 200, 2, 1, 1);
        start_pulse();
        wait_idle("t4b", 200);
        chk("t4b_scan_cnt", int'(scan_cnt), 1);
        end_check("t4b", 1);

        // REPEAT=0: done straight away, no load, block stays in reset
        cfg(2'd2, 0);
        push(K_DONE, 1, 0);
        start_pulse();
        wait_idle("t5", 20);
        chk("t5_sm_rst_n", int'(sm_rst_n), 0);
        end_check("t5", 0);

        // Asynchronous reset in the middle of LOAD_D
        cfg(2'd2, 2); cfg(2'd0, 50);
        timecount_in = TW'(3); k_model = 1;
        mon_en = 1'b0;
        start_pulse();
        n = 0;
        while (!(load && loadchoice) && n < 20) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("t6_reached_load_d", int'(load && loadchoice), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        @(posedge clk_sys); #1;
        q.delete();
        mon_en = 1'b1;
        // Config cleared by reset, so REPEAT is 0 again
        push(K_DONE, 0, 0);
        start_pulse();
        wait_idle("t6", 20);
        end_check("t6", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
